// File: rtl/dot_pipe_if.sv
// dot_pipe operand/result handshake bundle.
// Master drives the FIFO-side inputs; slave is the engine.
interface dot_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM        = 3
);
  logic [DIM-1:0][DATA_WIDTH-1:0] x;
  logic [DIM-1:0][DATA_WIDTH-1:0] y;
  logic                           mode;
  logic                           in_empty;
  logic                           in_rd_en;
  logic [DATA_WIDTH-1:0]          out;
  logic                           out_full;
  logic                           out_wr_en;
  logic                           overflow;
  logic                           busy;

  modport master (
    output x, y, mode, in_empty, out_full,
    input  in_rd_en, out, out_wr_en, overflow, busy
  );

  modport slave (
    input  x, y, mode, in_empty, out_full,
    output in_rd_en, out, out_wr_en, overflow, busy
  );
endinterface

// File: rtl/dot_pipe.sv
// dot_pipe: 3-stage fixed-point dot product / squared norm.
// FWFT source, FIFO sink, whole-pipe freeze on sink full.
module dot_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int Q_BITS     = 16,
  parameter int DIM        = 3,
  parameter bit SATURATE   = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  dot_pipe_if.slave  bus
);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int PW     = PROD_W - Q_BITS;
  localparam int SUM_W  = PW + $clog2(DIM + 1);

  localparam logic signed [SUM_W-1:0] MAXV =
    SUM_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] MINV = ~MAXV;

  localparam logic [DATA_WIDTH-1:0] RMAX =
    {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] RMIN =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic                         s1_valid_q, s2_valid_q, s3_valid_q;
  logic                         stall, accept;
  logic signed [DATA_WIDTH-1:0] xs, bs;
  logic signed [PROD_W-1:0]     prod, sh;
  logic signed [PW-1:0]         p_d [DIM];
  logic signed [PW-1:0]         p_q [DIM];
  logic signed [SUM_W-1:0]      sum_d, sum_q;
  logic [DATA_WIDTH-1:0]        res_d, res_q;
  logic                         ovf_d, ovf_q;
  logic                         overflow_q;
  logic                         hi, lo;

  assign stall  = s3_valid_q & bus.out_full;
  assign accept = ~reset & ~bus.in_empty & ~stall;

  assign bus.in_rd_en  = accept;
  assign bus.out_wr_en = ~reset & s3_valid_q & ~bus.out_full;
  assign bus.out       = reset ? '0 : res_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      =
    ~reset & (s1_valid_q | s2_valid_q | s3_valid_q);

  // S1 products, rescaled by arithmetic shift (floor)
  always_comb begin
    xs   = '0;
    bs   = '0;
    prod = '0;
    sh   = '0;
    for (int i = 0; i < DIM; i++) begin
      xs = $signed(bus.x[i]);
      bs = bus.mode ? $signed(bus.x[i])
                    : $signed(bus.y[i]);
      prod = PROD_W'(xs) * PROD_W'(bs);
      sh   = prod >>> Q_BITS;
      p_d[i] = sh[PW-1:0];
    end
  end

  // S2 full-width sum, no intermediate truncation
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < DIM; i++)
      sum_d = sum_d + SUM_W'(p_q[i]);
  end

  // S3 clamp or wrap, flag out-of-range sums
  always_comb begin
    hi    = sum_q > MAXV;
    lo    = sum_q < MINV;
    ovf_d = hi | lo;
    res_d = sum_q[DATA_WIDTH-1:0];
    if (SATURATE) begin
      if (hi)
        res_d = RMAX;
      else if (lo)
        res_d = RMIN;
    end
  end

  // valid bits and sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (!stall) begin
        s1_valid_q <= accept;
        s2_valid_q <= s1_valid_q;
        s3_valid_q <= s2_valid_q;
      end
      overflow_q <= overflow_q | (bus.out_wr_en & ovf_q);
    end
  end

  // stage data, frozen as a whole on stall
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DIM; i++)
        p_q[i] <= '0;
      sum_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else if (!stall) begin
      if (accept)
        for (int i = 0; i < DIM; i++)
          p_q[i] <= p_d[i];
      sum_q <= sum_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
    end
  end
endmodule
